// File: rtl/cordic_rr_scheduler_if.sv
// Requester-side bundle of the CORDIC round-robin scheduler: operand handshake and result strobe.
interface cordic_rr_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    res_valid;
    logic [31:0]         res_data;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  res_valid,
        input  res_data
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output res_valid,
        output res_data
    );
endinterface

// File: rtl/cordic_rr_scheduler.sv
// Round-robin sharing of one free-running pipelined CORDIC between N_REQ requesters, with tag-tracked
// result routing. Optional macro CORDIC_RR_STATS_EN adds per-requester saturating grant counters.
module cordic_rr_scheduler #(
    parameter int  N_REQ      = 4,
    parameter int  CORDIC_LAT = 16,
    localparam int ID_W       = $clog2(N_REQ),
    localparam int INF_W      = $clog2(CORDIC_LAT + 3)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    cordic_rr_scheduler_if.slave  bus,
    output logic [31:0]           cordic_in,
    input  logic [31:0]           cordic_out,
    output logic [INF_W-1:0]      inflight
`ifdef CORDIC_RR_STATS_EN
    ,
    output logic [16*N_REQ-1:0]   stat_grants
`endif
);

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    logic [ID_W-1:0]  ptr_r;
    logic [ID_W:0]    sum_s;
    logic             found_s;
    logic [ID_W-1:0]  grant_id_s;
    logic [N_REQ-1:0] grant_s;
    logic             hs_s;
    logic [31:0]      sel_data_s;
    logic             retire_s;

    // Tag 0 is the issue-stage tag; tag CORDIC_LAT lines up with the matching cordic_out.
    logic [CORDIC_LAT:0] tag_valid_r;
    logic [ID_W-1:0]     tag_id_r [0:CORDIC_LAT];

    // Rotating-priority search starting just after the last granted requester.
    always_comb begin
        found_s    = 1'b0;
        grant_id_s = '0;
        sum_s      = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            sum_s = {1'b0, ptr_r} + (ID_W + 1)'(off);
            if (sum_s >= (ID_W + 1)'(N_REQ)) begin
                sum_s = sum_s - (ID_W + 1)'(N_REQ);
            end else begin
                sum_s = sum_s;
            end
            if (!found_s && bus.req_valid[sum_s[ID_W-1:0]]) begin
                found_s    = 1'b1;
                grant_id_s = sum_s[ID_W-1:0];
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Grant is suppressed during flush and while reset is asserted.
    always_comb begin
        if (found_s && rst_n && !flush) begin
            grant_s = onehot(grant_id_s);
        end else begin
            grant_s = '0;
        end
    end

    assign bus.req_ready = grant_s;
    assign hs_s          = |grant_s;
    assign sel_data_s    = bus.req_data[32*grant_id_s +: 32];
    assign retire_s      = |bus.res_valid;

    // Issue stage and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cordic_in <= 32'h0000_0000;
            ptr_r     <= ID_W'(N_REQ - 1);
        end else if (hs_s) begin
            cordic_in <= sel_data_s;
            ptr_r     <= grant_id_s;
        end else begin
            cordic_in <= 32'h0000_0000;
            ptr_r     <= ptr_r;
        end
    end

    // Tag pipeline: shifts every cycle, valids wiped by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_r <= '0;
            for (int i = 0; i <= CORDIC_LAT; i++) begin
                tag_id_r[i] <= '0;
            end
        end else begin
            if (flush) begin
                tag_valid_r <= '0;
            end else begin
                tag_valid_r <= {tag_valid_r[CORDIC_LAT-1:0], hs_s};
            end
            tag_id_r[0] <= grant_id_s;
            for (int i = 1; i <= CORDIC_LAT; i++) begin
                tag_id_r[i] <= tag_id_r[i-1];
            end
        end
    end

    // Retire: steer the CORDIC result to its requester; res_data holds between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.res_valid <= '0;
            bus.res_data  <= 32'h0000_0000;
        end else if (flush) begin
            bus.res_valid <= '0;
            bus.res_data  <= bus.res_data;
        end else if (tag_valid_r[CORDIC_LAT]) begin
            bus.res_valid <= onehot(tag_id_r[CORDIC_LAT]);
            bus.res_data  <= cordic_out;
        end else begin
            bus.res_valid <= '0;
            bus.res_data  <= bus.res_data;
        end
    end

    // An op counts from the cycle after its grant through the cycle of its result strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (flush) begin
            inflight <= '0;
        end else if (hs_s && !retire_s) begin
            inflight <= inflight + INF_W'(1);
        end else if (retire_s && !hs_s) begin
            inflight <= inflight - INF_W'(1);
        end else begin
            inflight <= inflight;
        end
    end

`ifdef CORDIC_RR_STATS_EN
    // Saturating per-requester grant counters; only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grants <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_s[i] && (stat_grants[16*i +: 16] != 16'hFFFF)) begin
                    stat_grants[16*i +: 16] <= stat_grants[16*i +: 16] + 16'd1;
                end else begin
                    stat_grants[16*i +: 16] <= stat_grants[16*i +: 16];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler: stand-in pipelined CORDIC plus a cycle-indexed result schedule model.
`timescale 1ns/1ps
module tb_cordic_rr_scheduler;
    localparam int N   = 4;
    localparam int LAT = 16;
    localparam int RL  = LAT + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] cordic_in;
    logic [31:0] cordic_out;
    logic [4:0]  inflight;
`ifdef CORDIC_RR_STATS_EN
    logic [16*N-1:0] stat_grants;
`endif

    cordic_rr_scheduler_if #(.N_REQ(N)) bus ();

    cordic_rr_scheduler #(.N_REQ(N), .CORDIC_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
        .cordic_in(cordic_in), .cordic_out(cordic_out), .inflight(inflight)
`ifdef CORDIC_RR_STATS_EN
        , .stat_grants(stat_grants)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in CORDIC transfer function; any bijection works for routing checks.
    function automatic logic [31:0] cfun(input logic [31:0] x);
        return {x[30:0], x[31]} ^ 32'h3C5A_96E1;
    endfunction

    logic [31:0] cpipe [LAT];
    always @(posedge clk) begin
        cpipe[0] <= cfun(cordic_in);
        for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
    end
    assign cordic_out = cpipe[LAT-1];

    // Reference model: results scheduled by absolute cycle number (slot = cycle mod 64).
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          m_ptr;
    int          m_gid;
    logic [N-1:0]  m_gnt;
    logic [N-1:0]  m_rv [64];
    logic [31:0]   m_rd [64];
    logic [31:0]   m_ci;
    logic [31:0]   m_last;
    int            m_stat [N];

    function automatic logic [4:0] exp_inf();
        int c = 0;
        for (int k = 0; k < RL; k++) if (m_rv[(cyc + k) % 64] != '0) c++;
        return 5'(c);
    endfunction

    function automatic logic [31:0] exp_rd();
        return (m_rv[cyc % 64] != '0) ? m_rd[cyc % 64] : m_last;
    endfunction

    task automatic model_reset();
        m_ptr = N - 1; m_ci = 32'h0; m_last = 32'h0;
        for (int i = 0; i < 64; i++) begin m_rv[i] = '0; m_rd[i] = 32'h0; end
        for (int i = 0; i < N; i++) m_stat[i] = 0;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic fl);
        bus.req_valid = v;
        flush = fl;
        for (int i = 0; i < N; i++) bus.req_data[32*i +: 32] = $urandom;
        m_gnt = '0; m_gid = -1;
        if (rst_n && !fl) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (m_gid < 0 && v[j]) begin m_gid = j; m_gnt[j] = 1'b1; end
            end
        end
    endtask

    task automatic advance();
        logic [31:0] d;
        @(posedge clk);
        if (m_rv[cyc % 64] != '0) m_last = m_rd[cyc % 64];
        m_rv[cyc % 64] = '0;
        if (!rst_n) begin
            m_ci = 32'h0;
        end else begin
            if (m_gid >= 0) begin
                d = bus.req_data[32*m_gid +: 32];
                m_rv[(cyc + RL) % 64] = m_gnt;
                m_rd[(cyc + RL) % 64] = cfun(d);
                m_ptr = m_gid; m_ci = d; m_stat[m_gid]++;
            end else begin
                m_ci = 32'h0;
            end
            if (flush) for (int k = 1; k <= RL; k++) m_rv[(cyc + k) % 64] = '0;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        for (int t = 0; t < 2; t++) begin drive('0, 1'b0); advance(); end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; bus.req_valid = '0; bus.req_data = '0;
        model_reset();
        #2;
        for (int t = 0; t < 3; t++) begin
            drive(4'b1111, 1'b0);
            @(negedge clk);
            n_cmp++;
            if ({bus.req_ready, bus.res_valid, bus.res_data, cordic_in, inflight} !== '0) begin
                n_err++;
                $display("FAIL reset t=%0d rdy=%h rv=%h rd=%h ci=%h inf=%0d exp all 0",
                         t, bus.req_ready, bus.res_valid, bus.res_data, cordic_in, inflight);
            end
            advance();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [31:0] op = 32'h3f40_0000;
        for (int t = 0; t <= 22; t++) begin
            drive((t == 0) ? 4'b0001 : 4'b0000, 1'b0);
            if (t == 0) bus.req_data[31:0] = op;
            @(negedge clk);
            n_cmp++;
            if ({bus.req_ready, bus.res_valid, inflight} !== {m_gnt, m_rv[cyc % 64], exp_inf()}) begin
                n_err++;
                $display("FAIL single t=%0d rdy/rv/inf got %h/%h/%0d exp %h/%h/%0d", t, bus.req_ready,
                         bus.res_valid, inflight, m_gnt, m_rv[cyc % 64], exp_inf());
            end
            n_cmp++;
            if ({cordic_in, bus.res_data} !== {m_ci, exp_rd()}) begin
                n_err++;
                $display("FAIL single_data t=%0d ci/rd got %h/%h exp %h/%h", t, cordic_in,
                         bus.res_data, m_ci, exp_rd());
            end
            if (t == 0 || t == 1 || t == 18) begin
                n_cmp++;
                if ((t == 0 && bus.req_ready !== 4'b0001) || (t == 1 && cordic_in !== op) ||
                    (t == 18 && (bus.res_valid !== 4'b0001 || bus.res_data !== cfun(op)))) begin
                    n_err++;
                    $display("FAIL single_fixed t=%0d rdy=%h ci=%h rv=%h rd=%h exp_rd=%h", t,
                             bus.req_ready, cordic_in, bus.res_valid, bus.res_data, cfun(op));
                end
            end
            advance();
        end
    endtask

    task automatic test_all4();
        int peak = 0;
        do_reset();
        for (int t = 0; t <= 32; t++) begin
            drive((t < 12) ? 4'b1111 : 4'b0000, 1'b0);
            @(negedge clk);
            if (int'(inflight) > peak) peak = int'(inflight);
            n_cmp++;
            if ({bus.req_ready, bus.res_valid, inflight} !== {m_gnt, m_rv[cyc % 64], exp_inf()}) begin
                n_err++;
                $display("FAIL all4 t=%0d rdy/rv/inf got %h/%h/%0d exp %h/%h/%0d", t, bus.req_ready,
                         bus.res_valid, inflight, m_gnt, m_rv[cyc % 64], exp_inf());
            end
            n_cmp++;
            if ({cordic_in, bus.res_data} !== {m_ci, exp_rd()}) begin
                n_err++;
                $display("FAIL all4_data t=%0d ci/rd got %h/%h exp %h/%h", t, cordic_in,
                         bus.res_data, m_ci, exp_rd());
            end
            if (t < 12) begin
                n_cmp++;
                if (bus.req_ready !== 4'(1 << (t % 4))) begin
                    n_err++;
                    $display("FAIL all4_order t=%0d got %h exp %h", t, bus.req_ready, 4'(1 << (t % 4)));
                end
            end
            if (t >= RL && t < RL + 12) begin
                n_cmp++;
                if (bus.res_valid !== 4'(1 << ((t - RL) % 4))) begin
                    n_err++;
                    $display("FAIL all4_retire t=%0d got %h exp %h", t, bus.res_valid,
                             4'(1 << ((t - RL) % 4)));
                end
            end
            advance();
        end
        n_cmp++;
        if (peak !== 12) begin n_err++; $display("FAIL all4_peak got %0d exp 12", peak); end
    endtask

    task automatic test_wrap();
        for (int t = 0; t <= 24; t++) begin
            drive((t == 0) ? 4'b0010 : (t < 3) ? 4'b1010 : 4'b0000, 1'b0);
            @(negedge clk);
            n_cmp++;
            if ({bus.req_ready, bus.res_valid, inflight, cordic_in, bus.res_data} !==
                {m_gnt, m_rv[cyc % 64], exp_inf(), m_ci, exp_rd()}) begin
                n_err++;
                $display("FAIL wrap t=%0d rdy/rv/inf/ci/rd got %h/%h/%0d/%h/%h exp %h/%h/%0d/%h/%h", t,
                         bus.req_ready, bus.res_valid, inflight, cordic_in, bus.res_data,
                         m_gnt, m_rv[cyc % 64], exp_inf(), m_ci, exp_rd());
            end
            if (t == 1 || t == 2) begin
                n_cmp++;
                if (bus.req_ready !== ((t == 1) ? 4'b1000 : 4'b0010)) begin
                    n_err++;
                    $display("FAIL wrap_grant t=%0d got %h exp %h", t, bus.req_ready,
                             (t == 1) ? 4'b1000 : 4'b0010);
                end
            end
            advance();
        end
    endtask

    task automatic test_flush();
        logic [N-1:0] g9 = '0;
        for (int t = 0; t <= 30; t++) begin
            drive((t < 5 || t == 8 || t == 9) ? 4'($urandom_range(1, 15)) : 4'b0000, t == 8);
            @(negedge clk);
            if (t == 9) g9 = m_gnt;
            n_cmp++;
            if ({bus.req_ready, bus.res_valid, inflight, cordic_in, bus.res_data} !==
                {m_gnt, m_rv[cyc % 64], exp_inf(), m_ci, exp_rd()}) begin
                n_err++;
                $display("FAIL flush t=%0d rdy/rv/inf/ci/rd got %h/%h/%0d/%h/%h exp %h/%h/%0d/%h/%h", t,
                         bus.req_ready, bus.res_valid, inflight, cordic_in, bus.res_data,
                         m_gnt, m_rv[cyc % 64], exp_inf(), m_ci, exp_rd());
            end
            if (t == 8 || t == 9 || t == 27) begin
                n_cmp++;
                if ((t == 8 && bus.req_ready !== 4'b0000) || (t == 9 && inflight !== 5'd0) ||
                    (t == 27 && bus.res_valid !== g9)) begin
                    n_err++;
                    $display("FAIL flush_fixed t=%0d rdy=%h inf=%0d rv=%h g9=%h", t, bus.req_ready,
                             inflight, bus.res_valid, g9);
                end
            end
            advance();
        end
    endtask

    task automatic test_midreset();
        do_reset();
        for (int t = 0; t < 6; t++) begin drive(4'($urandom_range(1, 15)), 1'b0); advance(); end
        rst_n = 1'b0;
        model_reset();
        drive(4'b1111, 1'b0);
        #1;
        n_cmp++;
        if ({bus.req_ready, bus.res_valid, bus.res_data, cordic_in, inflight} !== '0) begin
            n_err++;
            $display("FAIL midreset_async rdy=%h rv=%h rd=%h ci=%h inf=%0d exp all 0",
                     bus.req_ready, bus.res_valid, bus.res_data, cordic_in, inflight);
        end
        for (int t = 0; t <= 26; t++) begin
            if (t == 2) rst_n = 1'b1;
            drive((t == 26) ? 4'b1111 : 4'b0000, 1'b0);
            @(negedge clk);
            n_cmp++;
            if ({bus.req_ready, bus.res_valid, inflight, cordic_in, bus.res_data} !==
                {m_gnt, m_rv[cyc % 64], exp_inf(), m_ci, exp_rd()}) begin
                n_err++;
                $display("FAIL midreset t=%0d rdy/rv/inf/ci/rd got %h/%h/%0d/%h/%h exp %h/%h/%0d/%h/%h", t,
                         bus.req_ready, bus.res_valid, inflight, cordic_in, bus.res_data,
                         m_gnt, m_rv[cyc % 64], exp_inf(), m_ci, exp_rd());
            end
            if (t == 26) begin
                n_cmp++;
                if (bus.req_ready !== 4'b0001) begin
                    n_err++;
                    $display("FAIL midreset_first_grant got %h exp 0001", bus.req_ready);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            drive(4'($urandom_range(0, 15)), ($urandom_range(0, 23) == 0) && (t < 380));
            @(negedge clk);
            n_cmp++;
            if ({bus.req_ready, bus.res_valid, inflight, cordic_in, bus.res_data} !==
                {m_gnt, m_rv[cyc % 64], exp_inf(), m_ci, exp_rd()}) begin
                n_err++;
                $display("FAIL random t=%0d rdy/rv/inf/ci/rd got %h/%h/%0d/%h/%h exp %h/%h/%0d/%h/%h", t,
                         bus.req_ready, bus.res_valid, inflight, cordic_in, bus.res_data,
                         m_gnt, m_rv[cyc % 64], exp_inf(), m_ci, exp_rd());
            end
            advance();
        end
    endtask

`ifdef CORDIC_RR_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int t = 0; t < 70000; t++) begin drive(4'b0100, 1'b0); advance(); end
        drive('0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (stat_grants[16*i +: 16] !== ((m_stat[i] > 65535) ? 16'hFFFF : 16'(m_stat[i]))) begin
                n_err++;
                $display("FAIL stats req=%0d got %h exp %h", i, stat_grants[16*i +: 16],
                         (m_stat[i] > 65535) ? 16'hFFFF : 16'(m_stat[i]));
            end
        end
        advance();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all4();
        test_wrap();
        test_flush();
        test_midreset();
        test_random();
`ifdef CORDIC_RR_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
